fpu_result_fifo: RTL and testbench
==================================

Name: fpu_result_fifo

Overview:
- Sits directly downstream of the FPU result multiplexer (selects adder/multiplier/divider outputs by op).
- Captures each completed FPU result with its op code and exception flags into a small FIFO.
- Presents entries to the consumer over a valid/ready handshake.
- Keeps sticky exception flags and an accepted-result counter for status readout.

Parameters:
- DATA_W, 32, width of the IEEE-754 single-precision result word.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the accepted-result counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  mux output holds a completed result this cycle.
- in_ready  out  1  FIFO can accept (not full).
- in_op  in  2  op code of the result: 00 add, 01 sub, 10 mul, 11 div.
- in_result  in  DATA_W  selected result word.
- in_error  in  1  selected error flag.
- in_overflow  in  1  selected overflow flag.
- in_underflow  in  1  selected underflow flag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head entry.
- out_op  out  2  head op code.
- out_result  out  DATA_W  head result.
- out_error  out  1  head error flag.
- out_overflow  out  1  head overflow flag.
- out_underflow  out  1  head underflow flag.
- level  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- clear_flags  in  1  one-cycle pulse; clears sticky flags.
- sticky_error  out  1  sticky error flag.
- sticky_overflow  out  1  sticky overflow flag.
- sticky_underflow  out  1  sticky underflow flag.
- sticky_drop  out  1  sticky drop flag.
- result_count  out  CNT_W  number of accepted pushes.

Behaviour:
- Reset (rst=1 at clk edge):
  - Pointers and level go to 0; out_valid=0; all sticky flags=0; result_count=0.
  - out_* data outputs go to 0.
  - in_ready=1 the cycle after reset.
  - Reset mid-operation discards all stored entries.
- Entry format: {op[1:0], err, ovf, udf, result[DATA_W-1:0]}, stored atomically.
- Push: in_valid && in_ready. Pop: out_valid && out_ready.
- in_ready = (level != DEPTH); combinational from registered level, no dependence on out_ready.
- Full FIFO refuses a push even if a pop happens in the same cycle; no pass-through.
- out_valid = (level != 0). Output data is driven from the head entry (registered storage, muxed by read pointer).
- Latency: an entry pushed into an empty FIFO appears on out_* with out_valid=1 one cycle later. No combinational in-to-out path.
- Simultaneous push and pop (0 < level < DEPTH): level unchanged; both pointers advance.
- Pointers are log2(DEPTH)+1 bits with an MSB wrap bit. Full = equal index with differing MSB; empty = fully equal. Wrap-around is natural modulo 2*DEPTH.
- out_* must hold stable while out_valid && !out_ready.
- Sticky flags:
  - On an accepted push, each sticky_error/overflow/underflow ORs in its in_* flag.
  - sticky_drop sets when in_valid && !in_ready (result lost).
  - clear_flags zeroes all four sticky flags.
  - If clear_flags and a setting event occur in the same cycle, the new event wins: the flag is 1 after the edge.
- result_count increments by 1 per accepted push and wraps modulo 2^CNT_W. It is not affected by clear_flags.
- in_op is stored verbatim; the block does not interpret it.

Decomposition:
- Shared package fpu_pkg:
  - Op code constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11.
  - Entry field widths/offsets.
  - Flag bit positions (ERR, OVF, UDF).
- One natural sub-module: fpu_sync_fifo, a generic synchronous FIFO (WIDTH, DEPTH, push/pop, full/empty/level).
- fpu_result_fifo instantiates it and adds the sticky-flag and counter logic.

Test Plan:
- Reset then single push: op=10, result=32'h40490FDB, no flags -> next cycle out_valid=1, out_op=10, out_result=32'h40490FDB; level=1; result_count=1; sticky flags all 0.
- Fill with out_ready=0: push 4 entries 32'h3F800000..32'h40800000 -> level=4, in_ready=0. A 5th push with in_valid=1 -> dropped, sticky_drop=1, result_count stays 4. Then out_ready=1 drains 4 entries in order over 4 cycles.
- Streaming: in_valid=1 and out_ready=1 continuously for 20 cycles with incrementing results -> level stays at 1. Outputs come out in order with 1-cycle latency, crossing pointer wrap without loss.
- Flags: push div result 32'h7F800000 with ovf=1, then add result with err=1 -> sticky_overflow=1 and sticky_error=1. The matching out_overflow/out_error appear only on those entries.
- Clear collision: clear_flags=1 in the same cycle as an accepted push with udf=1 -> sticky_underflow=1 and the other sticky flags 0 after the edge.
- Reset mid-stream: level=3, assert rst for one cycle -> level=0, out_valid=0, all sticky flags 0, result_count=0; the next push appears after 1 cycle.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the FPU result path.
//   - op code constants as produced by the FPU result multiplexer
//   - field widths and bit positions of a stored result entry
// Entry layout (MSB..LSB): {op[1:0], err, ovf, udf, result[DATA_W-1:0]}
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int OP_W   = 2;
  localparam int FLAG_W = 3;

  // Flag bit positions inside the 3-bit flag field
  localparam int FLAG_UDF = 0;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_ERR = 2;

  // Entry geometry as a function of the result word width
  function automatic int entry_w(input int data_w);
    return data_w + FLAG_W + OP_W;
  endfunction

  function automatic int flag_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int op_lsb(input int data_w);
    return data_w + FLAG_W;
  endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// fpu_sync_fifo: generic single-clock FIFO.
// Ports:
//   clk, rst         clock, synchronous active-high reset (pointers only)
//   push, wdata      write request and data; ignored when full
//   pop              read request; ignored when empty
//   rdata            head entry (storage muxed by read pointer)
//   full, empty      occupancy status
//   level            occupancy 0..DEPTH
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter.
module fpu_sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);
  // Modulo 2*DEPTH difference yields 0..DEPTH for a power-of-two DEPTH
  assign level = wr_ptr - rd_ptr;

  // A full FIFO refuses the push even when a pop happens in the same cycle
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is data only; stale contents are unreachable after reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fpu_result_fifo.sv
// fpu_result_fifo: buffers completed FPU results (with op code and exception
// flags) between the FPU result multiplexer and its consumer.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              producer handshake (in_ready = not full)
//   in_op, in_result, in_error,
//   in_overflow, in_underflow      result entry fields
//   out_valid/out_ready            consumer handshake
//   out_op, out_result, out_error,
//   out_overflow, out_underflow    head entry fields (0 while empty)
//   level                          occupancy 0..DEPTH
//   clear_flags                    pulse clearing the sticky flags
//   sticky_error/overflow/underflow  OR of flags of accepted results
//   sticky_drop                    a result was offered while full
//   result_count                   accepted results, wraps modulo 2^CNT_W
module fpu_result_fifo
  import fpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [DATA_W-1:0]      in_result,
  input  logic                   in_error,
  input  logic                   in_overflow,
  input  logic                   in_underflow,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_op,
  output logic [DATA_W-1:0]      out_result,
  output logic                   out_error,
  output logic                   out_overflow,
  output logic                   out_underflow,
  output logic [$clog2(DEPTH):0] level,
  input  logic                   clear_flags,
  output logic                   sticky_error,
  output logic                   sticky_overflow,
  output logic                   sticky_underflow,
  output logic                   sticky_drop,
  output logic [CNT_W-1:0]       result_count
);

  localparam int ENTRY_W = entry_w(DATA_W);
  localparam int FL_LSB  = flag_lsb(DATA_W);
  localparam int OP_LSB  = op_lsb(DATA_W);

  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               drop;

  assign wr_entry = {in_op, in_error, in_overflow, in_underflow, in_result};

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign drop      = in_valid && !in_ready;

  fpu_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Gate the head with out_valid so data outputs read 0 after reset without
  // resetting the storage array itself
  assign out_result    = out_valid ? head[DATA_W-1:0]          : '0;
  assign out_underflow = out_valid ? head[FL_LSB + FLAG_UDF]   : 1'b0;
  assign out_overflow  = out_valid ? head[FL_LSB + FLAG_OVF]   : 1'b0;
  assign out_error     = out_valid ? head[FL_LSB + FLAG_ERR]   : 1'b0;
  assign out_op        = out_valid ? head[OP_LSB +: OP_W]      : 2'b00;

  // Clear first, then OR in this cycle's event so a colliding event survives
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_error     <= 1'b0;
      sticky_overflow  <= 1'b0;
      sticky_underflow <= 1'b0;
      sticky_drop      <= 1'b0;
      result_count     <= '0;
    end else begin
      sticky_error     <= (sticky_error     && !clear_flags) || (push && in_error);
      sticky_overflow  <= (sticky_overflow  && !clear_flags) || (push && in_overflow);
      sticky_underflow <= (sticky_underflow && !clear_flags) || (push && in_underflow);
      sticky_drop      <= (sticky_drop      && !clear_flags) || drop;
      if (push) result_count <= result_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fpu_result_fifo.sv
// Scoreboard bench for fpu_result_fifo: the driver queues the expected entry
// for every push it expects to be accepted; a negedge monitor pops and
// compares on every output handshake.
module tb_fpu_result_fifo;
  import fpu_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [DATA_W-1:0] in_result;
  logic              in_error, in_overflow, in_underflow;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_op;
  logic [DATA_W-1:0] out_result;
  logic              out_error, out_overflow, out_underflow;
  logic [2:0]        level;
  logic              clear_flags;
  logic              sticky_error, sticky_overflow, sticky_underflow, sticky_drop;
  logic [CNT_W-1:0]  result_count;

  fpu_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_op            (in_op),
    .in_result        (in_result),
    .in_error         (in_error),
    .in_overflow      (in_overflow),
    .in_underflow     (in_underflow),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_op           (out_op),
    .out_result       (out_result),
    .out_error        (out_error),
    .out_overflow     (out_overflow),
    .out_underflow    (out_underflow),
    .level            (level),
    .clear_flags      (clear_flags),
    .sticky_error     (sticky_error),
    .sticky_overflow  (sticky_overflow),
    .sticky_underflow (sticky_underflow),
    .sticky_drop      (sticky_drop),
    .result_count     (result_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;
  logic [DATA_W+4:0] sb [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every handshake against the scoreboard; also check
  // that a stalled head does not change
  logic [DATA_W+4:0] held;
  logic              hold_prev = 1'b0;
  always @(negedge clk) begin
    logic [DATA_W+4:0] cur;
    cur = {out_op, out_error, out_overflow, out_underflow, out_result};
    if (!rst) begin
      if (hold_prev) chk("stall_hold", 64'(cur), 64'(held));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got %0h expected none", cur);
        end else begin
          chk("pop_entry", 64'(cur), 64'(sb.pop_front()));
        end
      end
    end
    hold_prev = !rst && out_valid && !out_ready;
    held      = cur;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] res,
                      input logic e, input logic o, input logic u);
    in_valid = 1'b1; in_op = op; in_result = res;
    in_error = e; in_overflow = o; in_underflow = u;
    sb.push_back({op, e, o, u, res});
    exp_count++;
    cyc();
  endtask

  task automatic idle();
    in_valid = 1'b0; in_op = 2'b00; in_result = '0;
    in_error = 1'b0; in_overflow = 1'b0; in_underflow = 1'b0;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) cyc();
    out_ready = 1'b0;
  endtask

  task automatic chk_sticky(input string name, input logic [3:0] exp);
    chk(name, 64'({sticky_error, sticky_overflow, sticky_underflow, sticky_drop}), 64'(exp));
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; clear_flags = 1'b0;
    idle();
    repeat (2) cyc();
    rst = 1'b0;

    // Reset state
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk_sticky("rst_sticky", 4'b0000);
    chk("rst_count", 64'(result_count), 64'd0);

    // Single push, one-cycle latency
    send(OP_MUL, 32'h40490FDB, 1'b0, 1'b0, 1'b0);
    idle();
    chk("single_out_valid", 64'(out_valid), 64'd1);
    chk("single_out_op", 64'(out_op), 64'd2);
    chk("single_out_result", 64'(out_result), 64'h40490FDB);
    chk("single_level", 64'(level), 64'd1);
    chk("single_count", 64'(result_count), 64'd1);
    chk_sticky("single_sticky", 4'b0000);
    drain(1);
    chk("single_drained", 64'(level), 64'd0);

    // Fill, drop on full, then drain in order
    send(OP_ADD, 32'h3F800000, 1'b0, 1'b0, 1'b0);
    send(OP_ADD, 32'h40000000, 1'b0, 1'b0, 1'b0);
    send(OP_ADD, 32'h40400000, 1'b0, 1'b0, 1'b0);
    send(OP_ADD, 32'h40800000, 1'b0, 1'b0, 1'b0);
    idle();
    chk("fill_level", 64'(level), 64'd4);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    chk("fill_count", 64'(result_count), 64'd5);
    in_valid = 1'b1; in_result = 32'h40A00000;
    cyc();
    idle();
    chk_sticky("drop_sticky", 4'b0001);
    chk("drop_count", 64'(result_count), 64'd5);
    chk("drop_level", 64'(level), 64'd4);
    drain(4);
    chk("fill_drained", 64'(level), 64'd0);

    // Streaming across pointer wrap
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(OP_SUB, 32'h00000100 + 32'(i), 1'b0, 1'b0, 1'b0);
      chk("stream_level", 64'(level), 64'd1);
    end
    idle();
    cyc();
    out_ready = 1'b0;
    chk("stream_drained", 64'(level), 64'd0);
    chk("stream_count", 64'(result_count), 64'd25);

    // Clear, then exception flags
    clear_flags = 1'b1;
    cyc();
    clear_flags = 1'b0;
    chk_sticky("clear_sticky", 4'b0000);
    send(OP_DIV, 32'h7F800000, 1'b0, 1'b1, 1'b0);
    send(OP_ADD, 32'h3F800000, 1'b1, 1'b0, 1'b0);
    idle();
    chk_sticky("flags_sticky", 4'b1100);
    drain(2);

    // Clear colliding with an underflow push
    clear_flags = 1'b1;
    send(OP_MUL, 32'h00000001, 1'b0, 1'b0, 1'b1);
    clear_flags = 1'b0;
    idle();
    chk_sticky("collide_sticky", 4'b0010);
    drain(1);

    // Full FIFO refuses a push even with a simultaneous pop
    send(OP_ADD, 32'h11111111, 1'b0, 1'b0, 1'b0);
    send(OP_SUB, 32'h22222222, 1'b0, 1'b0, 1'b0);
    send(OP_MUL, 32'h33333333, 1'b0, 1'b0, 1'b0);
    send(OP_DIV, 32'h44444444, 1'b0, 1'b0, 1'b0);
    in_result = 32'h55555555;
    out_ready = 1'b1;
    cyc();
    idle();
    out_ready = 1'b0;
    chk("fullpop_level", 64'(level), 64'd3);
    chk("fullpop_drop", 64'(sticky_drop), 64'd1);
    drain(3);

    // Reset mid-stream
    send(OP_ADD, 32'hAAAA0001, 1'b1, 1'b0, 1'b0);
    send(OP_ADD, 32'hAAAA0002, 1'b0, 1'b1, 1'b0);
    send(OP_ADD, 32'hAAAA0003, 1'b0, 1'b0, 1'b1);
    idle();
    chk("mid_level", 64'(level), 64'd3);
    rst = 1'b1;
    sb.delete();
    exp_count = 0;
    cyc();
    rst = 1'b0;
    chk("midrst_level", 64'(level), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_result", 64'(out_result), 64'd0);
    chk_sticky("midrst_sticky", 4'b0000);
    chk("midrst_count", 64'(result_count), 64'd0);
    send(OP_SUB, 32'hC0000000, 1'b1, 1'b1, 1'b1);
    idle();
    chk("post_out_valid", 64'(out_valid), 64'd1);
    chk("post_out_result", 64'(out_result), 64'hC0000000);
    chk("post_count", 64'(result_count), 64'(exp_count));
    drain(1);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
